seven_segment_display_receiver: RTL and testbench

Observes a multiplexed, active-low 4-digit seven-segment bus (commons + segments) and reconstructs the four displayed hex digits. It filters transition glitches with a per-sample stability counter and decodes each stable segment pattern back to a 4-bit value. It flags illegal patterns and signals when a complete frame has been captured. It is used as a loopback monitor on display-driver outputs and as the front end of display-scraping test fixtures.

---
 rtl/seven_segment_pkg.sv | 25 ++
 rtl/seven_segment_to_hex.sv | 35 +++
 rtl/seven_segment_display_receiver.sv | 130 +++++++++++++
 tb/tb_seven_segment_display_receiver.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment receiver: bus widths and the
// sixteen hex glyphs in active-high {g,f,e,d,c,b,a} form.
package seven_segment_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIGITS = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1110001;

endpackage

// File: rtl/seven_segment_to_hex.sv
// Combinational glyph decoder: active-high segment pattern to hex value.
// Unrecognised patterns (including all-off) report legal = 0 and hex = 0.
module seven_segment_to_hex
  import seven_segment_pkg::*;
(
  input  logic [SEG_W-1:0] s,
  output logic [3:0]       hex,
  output logic             legal
);

  always_comb begin
    hex   = 4'h0;
    legal = 1'b1;
    unique case (s)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_display_receiver.sv
// Reconstructs four hex digits from a multiplexed active-low 7-seg bus,
// accepting each {commons,segments} value once it has been stable long enough.
module seven_segment_display_receiver
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       commons,
  input  logic [SEG_W-1:0] segments,
  output logic [3:0]       hex0,
  output logic [3:0]       hex1,
  output logic [3:0]       hex2,
  output logic [3:0]       hex3,
  output logic [3:0]       digit_valid,
  output logic             pattern_error,
  output logic             frame_done
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned PIN_W = DIGITS + SEG_W;

  logic [PIN_W-1:0]           pins;
  logic [PIN_W-1:0]           sample_q, sample_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]     hex_q, hex_d;
  logic [DIGITS-1:0]          valid_q, valid_d;
  logic [DIGITS-1:0]          seen_q, seen_d;
  logic                       err_q, err_d;
  logic                       fd_q, fd_d;

  logic                       same;
  logic                       accept;
  logic [DIGITS-1:0]          c;
  logic [SEG_W-1:0]           s;
  logic                       one_hot;
  logic [1:0]                 idx;
  logic [3:0]                 dec_hex;
  logic                       dec_legal;

  assign pins   = {commons, segments};
  assign same   = (pins == sample_q);
  // Fires only on the edge that takes the counter into saturation.
  assign accept = same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
  assign c      = ~sample_q[PIN_W-1:SEG_W];
  assign s      = ~sample_q[SEG_W-1:0];
  assign one_hot = (c != '0) && ((c & (c - 4'd1)) == '0);

  seven_segment_to_hex u_to_hex (
    .s     (s),
    .hex   (dec_hex),
    .legal (dec_legal)
  );

  always_comb begin
    idx = 2'd0;
    case (c)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_comb begin
    sample_d = pins;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    hex_d   = hex_q;
    valid_d = valid_q;
    seen_d  = seen_q;
    err_d   = 1'b0;
    fd_d    = 1'b0;

    // A blanked interval (no common active) is accepted silently.
    if (accept && (c != '0)) begin
      if (!one_hot) begin
        err_d = 1'b1;
      end else if (dec_legal) begin
        hex_d[idx]   = dec_hex;
        valid_d[idx] = 1'b1;
        seen_d[idx]  = 1'b1;
        if (seen_d == '1) begin
          fd_d   = 1'b1;
          seen_d = '0;
        end
      end else begin
        valid_d[idx] = 1'b0;
        seen_d[idx]  = 1'b0;
        err_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sample_q <= {4'hF, 7'h7F};
      cnt_q    <= '0;
      hex_q    <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      err_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      fd_q     <= fd_d;
    end
  end

  assign hex0          = hex_q[0];
  assign hex1          = hex_q[1];
  assign hex2          = hex_q[2];
  assign hex3          = hex_q[3];
  assign digit_valid   = valid_q;
  assign pattern_error = err_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_seven_segment_display_receiver.sv
// Scoreboard bench: stimulus queues timestamped expected outputs, a monitor
// compares them on the falling edge and flags any change nobody expected.
module tb_seven_segment_display_receiver;

  localparam int unsigned STB = 4;

  typedef struct {
    int          cyc;
    logic [19:0] pers;
    logic        err;
    logic        fd;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] commons = 4'hF;
  logic [6:0] segments = 7'h7F;
  logic [3:0] hex0, hex1, hex2, hex3, digit_valid;
  logic       pattern_error, frame_done;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t q[$];

  seven_segment_display_receiver #(.STABLE_CYCLES(STB)) dut (
    .clock         (clock),
    .reset         (reset),
    .commons       (commons),
    .segments      (segments),
    .hex0          (hex0),
    .hex1          (hex1),
    .hex2          (hex2),
    .hex3          (hex3),
    .digit_valid   (digit_valid),
    .pattern_error (pattern_error),
    .frame_done    (frame_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
  endtask

  // Monitor
  logic [19:0] prev = '0;
  bit          armed = 1'b0;
  always @(negedge clock) begin
    logic [19:0] act;
    exp_t e;
    act = {hex3, hex2, hex1, hex0, digit_valid};
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("outputs", act, e.pers);
      chk("pattern_error", {19'd0, pattern_error}, {19'd0, e.err});
      chk("frame_done", {19'd0, frame_done}, {19'd0, e.fd});
      prev  = act;
      armed = 1'b1;
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_total++;
      $display("FAIL missed_event cycle %0d: expected event at cycle %0d", cyc, e.cyc);
    end else if (armed && (act !== prev || pattern_error !== 1'b0 || frame_done !== 1'b0)) begin
      n_total++;
      $display("FAIL unexpected_change cycle %0d: got %h err=%b fd=%b, expected %h err=0 fd=0",
               cyc, act, pattern_error, frame_done, prev);
      prev = act;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int at, input logic [19:0] pers, input logic err, input logic fd);
    exp_t e;
    e.cyc  = at;
    e.pers = pers;
    e.err  = err;
    e.fd   = fd;
    q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    commons  = 4'($urandom);
    segments = 7'($urandom);
    push(cyc + 1, 20'h00000, 1'b0, 1'b0);
    repeat (n) begin
      step();
      commons  = 4'($urandom);
      segments = 7'($urandom);
    end
    reset = 1'b0;
  endtask

  // Hold a pin value for n edges; optionally expect an accept STB+1 edges on.
  task automatic drive(input logic [3:0] c, input logic [6:0] s, input int n,
                       input bit has_exp, input logic [19:0] pers,
                       input logic err, input logic fd);
    commons  = c;
    segments = s;
    if (has_exp) push(cyc + STB + 1, pers, err, fd);
    repeat (n) step();
  endtask

  initial begin
    do_reset(2);
    drive(4'hF, 7'h7F, 8, 0, '0, 0, 0);
    // single digit, held long
    drive(4'b1110, 7'b1111001, 25, 1, 20'h00011, 0, 0);
    // short glitch on digit 1, then blank
    drive(4'b1101, 7'b0100100, 3, 0, '0, 0, 0);
    drive(4'b1101, 7'b1111111, 2, 0, '0, 0, 0);
    drive(4'hF, 7'h7F, 6, 0, '0, 0, 0);
    // all-off segments on digit 2, then two commons active
    drive(4'b1011, 7'b1111111, 6, 1, 20'h00011, 1, 0);
    drive(4'b1100, 7'b1111001, 6, 1, 20'h00011, 1, 0);
    // full frame 5, A, b, 3
    drive(4'b1110, 7'b0010010, 6, 1, 20'h00051, 0, 0);
    drive(4'b1101, 7'b0001000, 6, 1, 20'h00A53, 0, 0);
    drive(4'b1011, 7'b0000011, 6, 1, 20'h0BA57, 0, 0);
    drive(4'b0111, 7'b0110000, 6, 1, 20'h3BA5F, 0, 1);
    // second frame interrupted by reset
    drive(4'b1110, 7'b1111001, 6, 1, 20'h3BA1F, 0, 0);
    drive(4'b1101, 7'b0010010, 3, 0, '0, 0, 0);
    do_reset(2);
    drive(4'hF, 7'h7F, 6, 0, '0, 0, 0);
    // fresh frame in order 1,2,3,0: frame_done only on the last digit
    drive(4'b1101, 7'b0010010, 6, 1, 20'h00502, 0, 0);
    drive(4'b1011, 7'b0001000, 6, 1, 20'h0A506, 0, 0);
    drive(4'b0111, 7'b0000011, 6, 1, 20'hBA50E, 0, 0);
    drive(4'b1110, 7'b0100100, 6, 1, 20'hBA52F, 0, 1);
    drive(4'hF, 7'h7F, 8, 0, '0, 0, 0);

    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL pending_events: got %0d left, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
